// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for FD/DX/XM/MW: per-stage advance/hold/bubble decisions from
// load-use, redirect, I/D-memory stall and halt-drain events, plus a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] FD_rs,
  input  logic [REG_W-1:0] FD_rt,
  input  logic             FD_useRs,
  input  logic             FD_useRt,
  input  logic             FD_halt,
  input  logic             DX_memRead,
  input  logic [REG_W-1:0] DX_writeReg,
  input  logic             DX_regWrite,
  input  logic             X_redirect,
  input  logic             iMem_stall,
  input  logic             dMem_stall,
  input  logic             MW_halt,
  output logic             pc_en,
  output logic             FD_en,
  output logic             DX_en,
  output logic             XM_en,
  output logic             MW_en,
  output logic             FD_flush,
  output logic             DX_flush,
  output logic             XM_flush,
  output logic             MW_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

  state_t state, state_nxt;
  logic   load_use;

  // r0 is deliberately not special-cased: any specifier match stalls.
  assign load_use = DX_memRead & DX_regWrite &
                    ((FD_useRs & (FD_rs == DX_writeReg)) |
                     (FD_useRt & (FD_rt == DX_writeReg)));

  always_comb begin
    state_nxt = state;
    pc_en     = 1'b1;
    FD_en     = 1'b1;
    DX_en     = 1'b1;
    XM_en     = 1'b1;
    MW_en     = 1'b1;
    FD_flush  = 1'b0;
    DX_flush  = 1'b0;
    XM_flush  = 1'b0;
    MW_flush  = 1'b0;

    if (rst) begin
      state_nxt = RUN;
      pc_en     = 1'b0;
      FD_en     = 1'b0;
      DX_en     = 1'b0;
      XM_en     = 1'b0;
      MW_en     = 1'b0;
      FD_flush  = 1'b1;
      DX_flush  = 1'b1;
      XM_flush  = 1'b1;
      MW_flush  = 1'b1;
    end else begin
      case (state)
        // MEM_WAIT re-runs the full RUN priority once the data memory is ready,
        // so a redirect or hazard held during the wait is acted on then.
        RUN, MEM_WAIT: begin
          if (dMem_stall) begin
            pc_en     = 1'b0;
            FD_en     = 1'b0;
            DX_en     = 1'b0;
            XM_en     = 1'b0;
            MW_flush  = 1'b1;
            state_nxt = MEM_WAIT;
          end else if (X_redirect) begin
            FD_flush  = 1'b1;
            DX_flush  = 1'b1;
            state_nxt = RUN;
          end else if (load_use) begin
            pc_en     = 1'b0;
            FD_en     = 1'b0;
            DX_flush  = 1'b1;
            state_nxt = RUN;
          end else if (iMem_stall) begin
            pc_en     = 1'b0;
            FD_flush  = 1'b1;
            state_nxt = RUN;
          end else if (FD_halt) begin
            pc_en     = 1'b0;
            state_nxt = DRAIN;
          end else begin
            state_nxt = RUN;
          end
        end
        DRAIN: begin
          if (dMem_stall) begin
            pc_en    = 1'b0;
            FD_en    = 1'b0;
            DX_en    = 1'b0;
            XM_en    = 1'b0;
            MW_flush = 1'b1;
          end else if (X_redirect) begin
            // An older taken branch squashes the HALT still in flight.
            FD_flush  = 1'b1;
            DX_flush  = 1'b1;
            state_nxt = RUN;
          end else begin
            pc_en    = 1'b0;
            FD_flush = 1'b1;
            if (MW_halt) state_nxt = HALTED;
          end
        end
        HALTED: begin
          pc_en = 1'b0;
          FD_en = 1'b0;
          DX_en = 1'b0;
          XM_en = 1'b0;
          MW_en = 1'b0;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      halted    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state  <= state_nxt;
      halted <= (state_nxt == HALTED);
      if ((state != HALTED) && !pc_en && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; a narrow-counter instance checks saturation.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] FD_rs, FD_rt, DX_writeReg;
  logic       FD_useRs, FD_useRt, FD_halt, DX_memRead, DX_regWrite;
  logic       X_redirect, iMem_stall, dMem_stall, MW_halt;

  logic        pc_en, FD_en, DX_en, XM_en, MW_en;
  logic        FD_flush, DX_flush, XM_flush, MW_flush, halted;
  logic [15:0] stall_cnt;

  logic        pc_en_s, FD_en_s, DX_en_s, XM_en_s, MW_en_s;
  logic        FD_flush_s, DX_flush_s, XM_flush_s, MW_flush_s, halted_s;
  logic [3:0]  stall_cnt_s;

  logic [8:0] ctl, ctl_s;
  assign ctl   = {pc_en, FD_en, DX_en, XM_en, MW_en, FD_flush, DX_flush, XM_flush, MW_flush};
  assign ctl_s = {pc_en_s, FD_en_s, DX_en_s, XM_en_s, MW_en_s,
                  FD_flush_s, DX_flush_s, XM_flush_s, MW_flush_s};

  // {pc_en, FD..MW en, FD..MW flush}
  localparam logic [8:0] C_RUN   = 9'b11111_0000;
  localparam logic [8:0] C_RST   = 9'b00000_1111;
  localparam logic [8:0] C_LU    = 9'b00111_0100;
  localparam logic [8:0] C_DMEM  = 9'b00001_0001;
  localparam logic [8:0] C_REDIR = 9'b11111_1100;
  localparam logic [8:0] C_IMEM  = 9'b01111_1000;
  localparam logic [8:0] C_HALT  = 9'b01111_0000;
  localparam logic [8:0] C_DRAIN = 9'b01111_1000;
  localparam logic [8:0] C_STOP  = 9'b00000_0000;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .FD_rs(FD_rs), .FD_rt(FD_rt), .FD_useRs(FD_useRs),
    .FD_useRt(FD_useRt), .FD_halt(FD_halt), .DX_memRead(DX_memRead),
    .DX_writeReg(DX_writeReg), .DX_regWrite(DX_regWrite), .X_redirect(X_redirect),
    .iMem_stall(iMem_stall), .dMem_stall(dMem_stall), .MW_halt(MW_halt),
    .pc_en(pc_en), .FD_en(FD_en), .DX_en(DX_en), .XM_en(XM_en), .MW_en(MW_en),
    .FD_flush(FD_flush), .DX_flush(DX_flush), .XM_flush(XM_flush), .MW_flush(MW_flush),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.REG_W(3), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .FD_rs(FD_rs), .FD_rt(FD_rt), .FD_useRs(FD_useRs),
    .FD_useRt(FD_useRt), .FD_halt(FD_halt), .DX_memRead(DX_memRead),
    .DX_writeReg(DX_writeReg), .DX_regWrite(DX_regWrite), .X_redirect(X_redirect),
    .iMem_stall(iMem_stall), .dMem_stall(dMem_stall), .MW_halt(MW_halt),
    .pc_en(pc_en_s), .FD_en(FD_en_s), .DX_en(DX_en_s), .XM_en(XM_en_s), .MW_en(MW_en_s),
    .FD_flush(FD_flush_s), .DX_flush(DX_flush_s), .XM_flush(XM_flush_s),
    .MW_flush(MW_flush_s), .halted(halted_s), .stall_cnt(stall_cnt_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    FD_rs = 3'd0; FD_rt = 3'd0; FD_useRs = 1'b0; FD_useRt = 1'b0; FD_halt = 1'b0;
    DX_memRead = 1'b0; DX_writeReg = 3'd0; DX_regWrite = 1'b0;
    X_redirect = 1'b0; iMem_stall = 1'b0; dMem_stall = 1'b0; MW_halt = 1'b0;
  endtask

  // inputs change on the falling edge; checks run 1 time unit later
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    clr();
    step(); #1;
    chk("rst_ctl", ctl, C_RST);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_halted", halted, 0);

    // load-use on rs
    step(); rst = 1'b0;
    DX_memRead = 1; DX_regWrite = 1; DX_writeReg = 3'd3; FD_rs = 3'd3; FD_useRs = 1; #1;
    chk("lu_rs_ctl", ctl, C_LU);
    chk("lu_rs_cnt_before", stall_cnt, 0);
    step(); clr(); #1;
    chk("lu_rs_cnt_after", stall_cnt, 1);
    chk("run_idle_ctl", ctl, C_RUN);

    // same regs but not read -> no stall
    step(); DX_memRead = 1; DX_regWrite = 1; DX_writeReg = 3'd3; FD_rs = 3'd3; FD_rt = 3'd3; #1;
    chk("lu_nouse_ctl", ctl, C_RUN);
    // r0 match on rt still stalls
    step(); clr(); DX_memRead = 1; DX_regWrite = 1; FD_useRt = 1; #1;
    chk("lu_r0_ctl", ctl, C_LU);
    chk("lu_nouse_cnt", stall_cnt, 1);
    // load without regWrite -> no hazard
    step(); DX_regWrite = 0; #1;
    chk("lu_norw_ctl", ctl, C_RUN);
    chk("lu_r0_cnt", stall_cnt, 2);

    // dMem stall 3 cycles with redirect held
    for (int i = 0; i < 3; i++) begin
      step(); clr(); dMem_stall = 1; X_redirect = 1; #1;
      chk("dmem_ctl", ctl, C_DMEM);
    end
    step(); dMem_stall = 0; #1;
    chk("dmem_redir_ctl", ctl, C_REDIR);
    chk("dmem_cnt", stall_cnt, 5);

    // load-use held through a memory wait is applied afterwards
    step(); clr(); dMem_stall = 1; DX_memRead = 1; DX_regWrite = 1; FD_useRs = 1; #1;
    chk("dmem_lu_wait_ctl", ctl, C_DMEM);
    chk("redir_cnt", stall_cnt, 5);
    step(); dMem_stall = 0; #1;
    chk("dmem_lu_after_ctl", ctl, C_LU);
    // redirect beats load-use
    step(); X_redirect = 1; #1;
    chk("redir_over_lu_ctl", ctl, C_REDIR);
    chk("dmem_lu_cnt", stall_cnt, 7);
    // load-use beats iMem
    step(); X_redirect = 0; iMem_stall = 1; #1;
    chk("lu_over_imem_ctl", ctl, C_LU);
    step(); clr(); iMem_stall = 1; #1;
    chk("imem_ctl", ctl, C_IMEM);
    chk("imem_cnt_before", stall_cnt, 8);

    // halt drain
    step(); clr(); FD_halt = 1; #1;
    chk("halt_run_ctl", ctl, C_HALT);
    chk("halt_cnt_before", stall_cnt, 9);
    step(); clr(); #1;
    chk("drain1_ctl", ctl, C_DRAIN);
    step(); #1;
    chk("drain2_ctl", ctl, C_DRAIN);
    step(); MW_halt = 1; #1;
    chk("drain3_ctl", ctl, C_DRAIN);
    chk("drain3_halted", halted, 0);
    step(); MW_halt = 0; #1;
    chk("halted_ctl", ctl, C_STOP);
    chk("halted_flag", halted, 1);
    chk("halted_cnt", stall_cnt, 13);
    step(); iMem_stall = 1; X_redirect = 1; #1;
    chk("halted_hold_ctl", ctl, C_STOP);
    step(); clr(); #1;
    chk("halted_frozen_cnt", stall_cnt, 13);
    chk("halted_still", halted, 1);

    // reset out of HALTED
    step(); rst = 1; #1;
    chk("rst2_ctl", ctl, C_RST);
    step(); rst = 0; #1;
    chk("rst2_halted", halted, 0);
    chk("rst2_cnt", stall_cnt, 0);
    chk("rst2_ctl_run", ctl, C_RUN);

    // halt cancelled by a redirect during drain
    step(); FD_halt = 1; #1;
    chk("halt5_ctl", ctl, C_HALT);
    step(); clr(); dMem_stall = 1; #1;
    chk("drain_dmem_ctl", ctl, C_DMEM);
    step(); clr(); #1;
    chk("drain_after_dmem_ctl", ctl, C_DRAIN);
    step(); X_redirect = 1; #1;
    chk("drain_redir_ctl", ctl, C_REDIR);
    step(); clr(); #1;
    chk("back_run_ctl", ctl, C_RUN);
    chk("back_run_halted", halted, 0);
    chk("back_run_cnt", stall_cnt, 3);

    // saturation on the 4-bit counter, then reset mid memory wait
    step(); rst = 1; #1;
    for (int i = 0; i < 20; i++) begin
      step(); rst = 0; iMem_stall = 1; #1;
    end
    step(); clr(); #1;
    chk("sat_cnt16", stall_cnt, 20);
    chk("sat_cnt4", stall_cnt_s, 4'hF);
    step(); iMem_stall = 1; #1;
    chk("sat_ctl_s", ctl_s, C_IMEM);
    step(); clr(); dMem_stall = 1; #1;
    chk("sat_hold_cnt4", stall_cnt_s, 4'hF);
    step(); #1;
    chk("wait_ctl", ctl, C_DMEM);
    step(); rst = 1; #1;
    chk("rst_wait_ctl", ctl, C_RST);
    step(); rst = 0; dMem_stall = 0; #1;
    chk("rst_wait_ctl_run", ctl, C_RUN);
    chk("rst_wait_cnt16", stall_cnt, 0);
    chk("rst_wait_cnt4", stall_cnt_s, 0);
    chk("rst_wait_halted_s", halted_s, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
